regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register index width; DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 The block SHALL have port clock, input, 1, single clock; all state changes on rising edge.
REQ-005 The block SHALL have port ctrl_reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port ctrl_writeEnable, input, 1, write strobe.
REQ-007 The block SHALL have port ctrl_writeReg, input, ADDR_W, write index.
REQ-008 The block SHALL have port data_writeReg, input, DATA_W, write data.
REQ-009 The block SHALL have port ctrl_readReg, input, NUM_RD*ADDR_W, packed read indices; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port data_readReg, output, NUM_RD*DATA_W, packed read data; port k uses bits [k*DATA_W +: DATA_W].
REQ-011 The block SHALL have port clear_req, input, 1, request to zero all registers.
REQ-012 The block SHALL have port clear_busy, output, 1, high while the clear sweep runs.
REQ-013 The block SHALL have port clear_done, output, 1, one-cycle pulse when the sweep completes.

Function
REQ-014 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded.
REQ-015 Writes SHALL commit at the rising edge when ctrl_writeEnable=1, clear_busy=0, clear_req=0.
REQ-016 Reads SHALL be combinational from the stored array, with each read port independent and any port allowed to alias another.
REQ-017 FSM states SHALL be IDLE, SWEEP, and DONE.
REQ-018 In IDLE, clear_req=1 SHALL move the FSM to SWEEP and load sweep index to 1.
REQ-019 In SWEEP, one register (at the sweep index) SHALL be zeroed per cycle and the index incremented; after index DEPTH-1 is zeroed, the FSM SHALL move to DONE.
REQ-020 DONE SHALL last one cycle with clear_done=1, then return to IDLE.
REQ-021 clear_busy SHALL equal 1 in SWEEP only, so a sweep takes DEPTH-1 cycles of busy.
REQ-022 While in SWEEP or DONE, any read SHALL return 0 for every index, including those not yet swept.
REQ-023 While clear_busy=1 or in DONE, writes SHALL be discarded silently.
REQ-024 clear_req asserted outside IDLE SHALL be ignored, with no queuing.
REQ-025 If clear_req and a write coincide in IDLE, the clear SHALL win and the write SHALL be discarded.
REQ-026 The sweep index SHALL be ADDR_W wide and SHALL NOT wrap past DEPTH-1.

Reset
REQ-027 ctrl_reset=0 SHALL asynchronously zero all registers, force the FSM to IDLE, and drive clear_busy=0 and clear_done=0.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep, leaving all registers 0 and the FSM in IDLE with no clear_done pulse.
REQ-029 After reset deasserts, the first write SHALL be accepted on the first rising edge.

Configuration
REQ-030 Macro REGFILE_MP_BYPASS_EN, when defined, SHALL make a read of the index being written in the same cycle (accepted write, index != 0) return data_writeReg combinationally.
REQ-031 Without REGFILE_MP_BYPASS_EN, such a read SHALL return the old stored value, and the new value SHALL be visible from the next cycle.

Verification
REQ-032 Reset, then for each index 0..31 write 32'h0000DEAD and read on port 0 next cycle -> index 0 reads 0, all others read 32'h0000DEAD.
REQ-033 Write 32'h12345678 to r5 with port 0 = r5 and port 1 = r5 in the same cycle -> both ports return 32'h12345678 if BYPASS_EN is defined, otherwise the old value, then 32'h12345678 the next cycle.
REQ-034 Fill r1..r31 with nonzero values and pulse clear_req -> clear_busy is high exactly 31 cycles, clear_done pulses once, and all reads return 0 afterwards.
REQ-035 During a sweep, write 32'hCAFEF00D to r7 and re-pulse clear_req -> the write is discarded, no second sweep starts, and r7 reads 0 after done.
REQ-036 Assert ctrl_reset low mid-sweep (cycle 10) -> clear_busy drops immediately, no clear_done pulse occurs, and all registers read 0.
REQ-037 With NUM_RD=4, read distinct indices 3, 9, 17, 31 after writing 3, 9, 17, 31 to them -> each port returns its own index value.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file (r0 hardwired to zero) with a timed clear sweep.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  input  logic                     ctrl_writeEnable,
  input  logic [ADDR_W-1:0]        ctrl_writeReg,
  input  logic [DATA_W-1:0]        data_writeReg,
  input  logic [NUM_RD*ADDR_W-1:0] ctrl_readReg,
  output logic [NUM_RD*DATA_W-1:0] data_readReg,
  input  logic                     clear_req,
  output logic                     clear_busy,
  output logic                     clear_done,
  output logic [1:0]               dbg_state
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_sweep_idx;
  logic [ADDR_W-1:0] w_sweep_idx_nxt;
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              w_sweep_last;
  logic              w_wr_accept;

  // Clear handshake: clear_req is sampled only in IDLE (no queuing); clear_busy is high
  // for the DEPTH-1 sweep cycles, then clear_done pulses for exactly one cycle.
  assign w_sweep_last = (r_sweep_idx == ADDR_W'(DEPTH - 1));
  assign w_wr_accept  = ctrl_writeEnable && (r_state == IDLE) && !clear_req
                        && (ctrl_writeReg != '0);
  assign dbg_state    = r_state;

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_state     <= IDLE;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sweep_idx_nxt = r_sweep_idx;
    clear_busy      = 1'b0;
    clear_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (clear_req) begin
          w_state_nxt     = SWEEP;
          w_sweep_idx_nxt = ADDR_W'(1);
        end
      end
      SWEEP: begin
        clear_busy = 1'b1;
        // Index stops at DEPTH-1 rather than wrapping.
        if (w_sweep_last) w_state_nxt = DONE;
        else              w_sweep_idx_nxt = r_sweep_idx + ADDR_W'(1);
      end
      DONE: begin
        clear_done  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (r_state == SWEEP) begin
      r_regs[r_sweep_idx] <= '0;
    end else if (w_wr_accept) begin
      r_regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_idx;
    logic [DATA_W-1:0] w_data;

    assign w_idx = ctrl_readReg[k*ADDR_W +: ADDR_W];

    // Outside IDLE the whole file reads as cleared, even not-yet-swept entries.
    always_comb begin
      w_data = r_regs[w_idx];
      if ((r_state != IDLE) || (w_idx == '0)) begin
        w_data = '0;
      end
`ifdef REGFILE_MP_BYPASS_EN
      else if (w_wr_accept && (w_idx == ctrl_writeReg)) begin
        w_data = data_writeReg;
      end
`endif
    end

    assign data_readReg[k*DATA_W +: DATA_W] = w_data;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp (4 read ports), covering writes,
// r0 behaviour, same-cycle read/write, clear sweep, and reset mid-sweep.
module tb_regfile_mp;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 4;
  localparam int DEPTH = 32;

  logic             clock = 1'b0;
  logic             ctrl_reset = 1'b0;
  logic             ctrl_writeEnable = 1'b0;
  logic [AW-1:0]    ctrl_writeReg = '0;
  logic [DW-1:0]    data_writeReg = '0;
  logic [NR*AW-1:0] ctrl_readReg = '0;
  logic [NR*DW-1:0] data_readReg;
  logic             clear_req = 1'b0;
  logic             clear_busy;
  logic             clear_done;
  logic [1:0]       dbg_state;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_errors = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readReg     (ctrl_readReg),
    .data_readReg     (data_readReg),
    .clear_req        (clear_req),
    .clear_busy       (clear_busy),
    .clear_done       (clear_done),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // ---------------- drivers ----------------
  task automatic do_write(input int idx, input logic [DW-1:0] d);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = AW'(idx);
    data_writeReg    = d;
    tick();
    ctrl_writeEnable = 1'b0;
    if (idx != 0) model[idx] = d;
  endtask

  // Drives four read indices, queues expectations, then pops and compares.
  task automatic read_ports(input string tag, input int i0, input int i1, input int i2,
                            input int i3, input bit force_zero);
    int idx [NR];
    idx = '{i0, i1, i2, i3};
    for (int k = 0; k < NR; k++) begin
      ctrl_readReg[k*AW +: AW] = AW'(idx[k]);
      exp_q.push_back(force_zero ? '0 : model[idx[k]]);
    end
    #1;
    for (int k = 0; k < NR; k++)
      check($sformatf("%s p%0d r%0d", tag, k, idx[k]), data_readReg[k*DW +: DW], exp_q.pop_front());
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_busy;
    int n_done;
    logic [DW-1:0] exp_val;

    model_clear();
    repeat (2) @(negedge clock);
    #1;
    check("reset busy", DW'(clear_busy), '0);
    check("reset done", DW'(clear_done), '0);
    check("reset state", DW'(dbg_state), '0);
    read_ports("reset read", 0, 1, 15, 31, 1'b0);
    @(negedge clock);
    ctrl_reset = 1'b1;

    // Every index written with the same word; r0 must keep reading zero.
    for (int i = 0; i < DEPTH; i++) begin
      do_write(i, 32'h0000_DEAD);
      ctrl_readReg[0 +: AW] = AW'(i);
      exp_q.push_back(i == 0 ? '0 : 32'h0000_DEAD);
      #1;
      check($sformatf("dead r%0d", i), data_readReg[0 +: DW], exp_q.pop_front());
    end

    // Same-cycle write/read of r5 on two aliased ports.
    ctrl_readReg     = {AW'(6), AW'(0), AW'(5), AW'(5)};
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = AW'(5);
    data_writeReg    = 32'h1234_5678;
`ifdef REGFILE_MP_BYPASS_EN
    exp_val = 32'h1234_5678;
`else
    exp_val = model[5];
`endif
    exp_q.push_back(exp_val);
    exp_q.push_back(exp_val);
    #1;
    check("same cycle p0", data_readReg[0 +: DW], exp_q.pop_front());
    check("same cycle p1", data_readReg[DW +: DW], exp_q.pop_front());
    tick();
    ctrl_writeEnable = 1'b0;
    model[5] = 32'h1234_5678;
    read_ports("after write r5", 5, 5, 0, 6, 1'b0);

    // Distinct indices on all four ports.
    do_write(3, 32'd3);
    do_write(9, 32'd9);
    do_write(17, 32'd17);
    do_write(31, 32'd31);
    read_ports("distinct", 3, 9, 17, 31, 1'b0);

    // Full clear sweep; the coincident write to r3 must lose to the clear.
    for (int i = 1; i < DEPTH; i++) do_write(i, $urandom | 32'h1);
    read_ports("filled", 1, 2, 30, 31, 1'b0);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = AW'(3);
    data_writeReg    = 32'hBEEF_0003;
    pulse_clear();
    ctrl_writeEnable = 1'b0;
    n_busy = 0;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (clear_busy) n_busy++;
      if (clear_done) n_done++;
      if (c == 0) read_ports("sweep unswept", 31, 30, 2, 0, 1'b1);
      if (c == 31) read_ports("done read", 31, 30, 2, 1, 1'b1);
      tick();
    end
    check("sweep busy cycles", DW'(n_busy), 32'd31);
    check("sweep done pulses", DW'(n_done), 32'd1);
    model_clear();
    for (int i = 0; i < DEPTH; i += 4) read_ports("after clear", i, i + 1, i + 2, i + 3, 1'b0);

    // Write and repeated clear_req during the sweep are both ignored.
    do_write(7, 32'h0000_0077);
    do_write(20, 32'h0000_0020);
    pulse_clear();
    n_busy = 0;
    n_done = 0;
    for (int c = 0; c < 45; c++) begin
      if (c == 10) begin
        clear_req        = 1'b1;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = AW'(7);
        data_writeReg    = 32'hCAFE_F00D;
      end else begin
        clear_req        = 1'b0;
        ctrl_writeEnable = 1'b0;
      end
      if (clear_busy) n_busy++;
      if (clear_done) n_done++;
      tick();
    end
    check("reclear busy cycles", DW'(n_busy), 32'd31);
    check("reclear done pulses", DW'(n_done), 32'd1);
    model_clear();
    read_ports("reclear read", 7, 20, 8, 6, 1'b0);

    // Reset in the middle of a sweep.
    do_write(30, 32'h0000_0030);
    do_write(2, 32'h0000_0002);
    pulse_clear();
    repeat (10) tick();
    ctrl_reset = 1'b0;
    #1;
    check("abort busy", DW'(clear_busy), '0);
    check("abort state", DW'(dbg_state), '0);
    n_done = 0;
    for (int c = 0; c < 3; c++) begin
      if (clear_done) n_done++;
      tick();
    end
    ctrl_reset = 1'b1;
    model_clear();
    read_ports("abort read", 30, 2, 31, 12, 1'b0);
    do_write(12, 32'h0000_ABCD);
    for (int c = 0; c < 4; c++) begin
      if (clear_done) n_done++;
      tick();
    end
    check("abort done pulses", DW'(n_done), '0);
    read_ports("post reset write", 12, 30, 2, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
